mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 4, cycles from read-request acceptance to the read response; legal range 1..15.
REQ-002 Parameter ADDR_BITS, default 10, log2 of the backing-store depth in 32-bit words.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 cm_ReadValid  input  1  read request from the cache, held high until cm_ReadReady is seen.
REQ-006 cm_ReadAddr  input  32  byte address of the read; word index is cm_ReadAddr[ADDR_BITS+1:2].
REQ-007 cm_ReadReady  output  1  one-cycle pulse, read data valid.
REQ-008 cm_ReadData  output  32  read data; meaningful only while cm_ReadReady=1.
REQ-009 cm_WriteValid  input  1  dirty-line write-back strobe; no backpressure, accepted every cycle it is high.
REQ-010 cm_WriteTag  input  28  word address of the write-back (byte address bits [29:2]); word index is cm_WriteTag[ADDR_BITS-1:0].
REQ-011 cm_WriteData  input  32  write-back data.
REQ-012 busy  output  1  high while a read is outstanding (states WAIT and RESP).

Function
REQ-013 Backing store SHALL be 2^ADDR_BITS x 32-bit words, initialised to zero at time 0, and SHALL NOT be cleared by Reset.
REQ-014 Read FSM SHALL have states IDLE, WAIT, RESP.
REQ-015 IDLE: cm_ReadValid=1 SHALL latch the word index and load the latency counter with 1; next state WAIT (RESP directly if LATENCY=1).
REQ-016 WAIT: the counter SHALL increment each cycle; when it equals LATENCY-1 the next state SHALL be RESP.
REQ-017 RESP: cm_ReadReady SHALL be 1 for exactly this one cycle; next state IDLE unconditionally.
REQ-018 A request accepted in cycle t SHALL produce cm_ReadReady=1 in cycle t+LATENCY.
REQ-019 The read address SHALL be latched at acceptance; changes on cm_ReadAddr during WAIT/RESP SHALL be ignored.
REQ-020 cm_ReadValid falling while in WAIT SHALL abort the request: return to IDLE next cycle, no cm_ReadReady pulse.
REQ-021 cm_ReadValid still high in the cycle after RESP SHALL be treated as a new request (accepted in IDLE); no back-to-back pulses.
REQ-022 cm_ReadData SHALL be registered, loaded on entry to RESP with the latched word, and SHALL be 0 in every cycle cm_ReadReady=0.
REQ-023 A write with cm_WriteValid=1 SHALL update the store at the clock edge ending that cycle, in any FSM state.
REQ-024 Write to the latched read index in the cycle the RESP data is loaded SHALL forward cm_WriteData to cm_ReadData (read-after-write).
REQ-025 Writes during WAIT to the latched index SHALL be visible in the eventual response.
REQ-026 Simultaneous read acceptance and write in IDLE SHALL both proceed; no priority stall.
REQ-027 Address bits above the index SHALL be ignored (aliasing permitted).

Reset
REQ-028 Reset=1 at a clock edge SHALL force state IDLE, counter 0, cm_ReadReady=0, cm_ReadData=0, busy=0 on the following cycle.
REQ-029 Reset mid-read SHALL drop the outstanding request without a response; a write coincident with Reset SHALL still be committed.
REQ-030 With Reset deasserted, a request held high SHALL be accepted in the first cycle after reset.

Verification
REQ-031 LATENCY=4: write 0xDEADBEEF to tag 0x0000010, then read 0x00000040 held high -> cm_ReadReady pulse exactly 4 cycles after acceptance, data 0xDEADBEEF, one cycle only.
REQ-032 Read 0x40 accepted, cm_ReadAddr changed to 0x80 next cycle -> response carries word 0x10 contents, not word 0x20.
REQ-033 Read accepted, cm_ReadValid dropped after 2 cycles -> no cm_ReadReady within 10 cycles, busy returns to 0, FSM IDLE.
REQ-034 Read of word 0x10 pending, write 0x12345678 to tag 0x10 in the RESP-load cycle -> cm_ReadData=0x12345678.
REQ-035 Reset asserted 2 cycles into a LATENCY=4 read -> no pulse, busy=0; prior stored word 0xDEADBEEF still read back afterwards.
REQ-036 LATENCY=1 with cm_ReadValid held continuously -> pulses every 2 cycles (ready, gap, ready), never back-to-back.

Source files
------------

// File: rtl/mem_responder_if.sv
// Cache-to-memory read/write-back channel between the cache controller and mem_responder.
// The cache side drives requests and write-backs; the responder returns read data.
interface mem_responder_if;
    logic        cm_ReadValid;
    logic [31:0] cm_ReadAddr;
    logic        cm_ReadReady;
    logic [31:0] cm_ReadData;
    logic        cm_WriteValid;
    logic [27:0] cm_WriteTag;
    logic [31:0] cm_WriteData;

    modport master (
        output cm_ReadValid, cm_ReadAddr, cm_WriteValid, cm_WriteTag, cm_WriteData,
        input  cm_ReadReady, cm_ReadData
    );

    modport slave (
        input  cm_ReadValid, cm_ReadAddr, cm_WriteValid, cm_WriteTag, cm_WriteData,
        output cm_ReadReady, cm_ReadData
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency memory model answering cache line-fill reads and absorbing dirty write-backs.
// Reads run through an IDLE/WAIT/RESP FSM; write-backs land in the store every cycle they are strobed.
module mem_responder #(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 10
) (
    input  logic            CLK,
    input  logic            Reset,
    mem_responder_if.slave  cm,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT    = 4'(LATENCY - 1);
    localparam bit         DIRECT_RESP = (LATENCY == 1);

    logic [31:0]          mem_r [0:(1 << ADDR_BITS) - 1];

    state_t               state_r;
    state_t               state_next_s;
    logic [3:0]           cnt_r;
    logic [3:0]           cnt_next_s;
    logic [ADDR_BITS-1:0] idx_r;
    logic [ADDR_BITS-1:0] idx_next_s;
    logic                 ready_r;
    logic [31:0]          data_r;
    logic                 busy_r;

    logic [ADDR_BITS-1:0] rd_idx_s;
    logic [ADDR_BITS-1:0] wr_idx_s;
    logic                 load_s;
    logic [31:0]          load_data_s;
    logic                 unused_s;

    assign rd_idx_s = cm.cm_ReadAddr[ADDR_BITS+1:2];
    assign wr_idx_s = cm.cm_WriteTag[ADDR_BITS-1:0];
    // Upper address bits alias onto the same word
    assign unused_s = ^{cm.cm_ReadAddr[31:ADDR_BITS+2], cm.cm_ReadAddr[1:0],
                        cm.cm_WriteTag[27:ADDR_BITS]};

    // Next-state, counter and index latch for the read FSM
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        idx_next_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (cm.cm_ReadValid == 1'b1) begin
                    idx_next_s   = rd_idx_s;
                    cnt_next_s   = 4'd1;
                    state_next_s = DIRECT_RESP ? RESP : WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cm.cm_ReadValid == 1'b0) begin
                    state_next_s = IDLE;
                    cnt_next_s   = 4'd0;
                end else if (cnt_r == LAST_CNT) begin
                    state_next_s = RESP;
                    cnt_next_s   = cnt_r + 4'd1;
                end else begin
                    cnt_next_s   = cnt_r + 4'd1;
                end
            end
            RESP: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // Response word: a write-back hitting the latched index in the load cycle wins over the store
    always_comb begin
        load_s = (state_next_s == RESP) && (state_r != RESP);
        if ((cm.cm_WriteValid == 1'b1) && (wr_idx_s == idx_next_s)) begin
            load_data_s = cm.cm_WriteData;
        end else begin
            load_data_s = mem_r[idx_next_s];
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            idx_r   <= '0;
            ready_r <= 1'b0;
            data_r  <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            idx_r   <= idx_next_s;
            ready_r <= load_s;
            data_r  <= load_s ? load_data_s : 32'd0;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Backing store is deliberately outside reset so write-backs survive it
    always_ff @(posedge CLK) begin
        if (cm.cm_WriteValid == 1'b1) begin
            mem_r[wr_idx_s] <= cm.cm_WriteData;
        end
    end

    assign cm.cm_ReadReady = ready_r;
    assign cm.cm_ReadData  = data_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: LATENCY=4 and LATENCY=1 instances, response scoreboard.
module tb_mem_responder;

    logic CLK = 1'b0;
    logic Reset;
    logic busy4;
    logic busy1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        wr_en;
        logic [27:0] tag;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    exp_t q4[$];
    exp_t q1[$];

    mem_responder_if a4 ();
    mem_responder_if a1 ();

    mem_responder #(.LATENCY(4), .ADDR_BITS(10)) dut4 (
        .CLK(CLK), .Reset(Reset), .cm(a4.slave), .busy(busy4));
    mem_responder #(.LATENCY(1), .ADDR_BITS(10)) dut1 (
        .CLK(CLK), .Reset(Reset), .cm(a1.slave), .busy(busy1));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard for the LATENCY=4 instance
    always @(negedge CLK) begin
        if (mon_en) begin
            if (a4.cm_ReadReady === 1'b1) begin
                if (q4.size() == 0) begin
                    chk("unexpected_pulse4", 32'd1, 32'd0);
                end else begin
                    chk("pulse_cycle4", 32'(cyc), 32'(q4[0].due));
                    chk("rdata4", a4.cm_ReadData, q4[0].data);
                    void'(q4.pop_front());
                end
            end else begin
                chk("idle_data4", a4.cm_ReadData, 32'd0);
                if (q4.size() != 0 && q4[0].due <= cyc) begin
                    chk("missed_pulse4", 32'd0, 32'd1);
                    void'(q4.pop_front());
                end
            end
        end
    end

    // Scoreboard for the LATENCY=1 instance
    always @(negedge CLK) begin
        if (mon_en) begin
            if (a1.cm_ReadReady === 1'b1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_pulse1", 32'd1, 32'd0);
                end else begin
                    chk("pulse_cycle1", 32'(cyc), 32'(q1[0].due));
                    chk("rdata1", a1.cm_ReadData, q1[0].data);
                    void'(q1.pop_front());
                end
            end else begin
                chk("idle_data1", a1.cm_ReadData, 32'd0);
                if (q1.size() != 0 && q1[0].due <= cyc) begin
                    chk("missed_pulse1", 32'd0, 32'd1);
                    void'(q1.pop_front());
                end
            end
        end
    end

    task automatic wr4(input logic [27:0] tag, input logic [31:0] d);
        a4.cm_WriteValid = 1'b1;
        a4.cm_WriteTag   = tag;
        a4.cm_WriteData  = d;
        tick();
        a4.cm_WriteValid = 1'b0;
    endtask

    // Read on dut4 from IDLE; address switches to addr2 one cycle in; optional write at offset wr_at
    task automatic rd4w(input logic [31:0] addr, input logic [31:0] addr2, input logic [31:0] exp,
                        input int wr_at, input logic [27:0] tag, input logic [31:0] d);
        a4.cm_ReadValid = 1'b1;
        a4.cm_ReadAddr  = addr;
        q4.push_back('{cyc + 4, exp});
        for (int k = 0; k < 4; k++) begin
            if (k == 1) a4.cm_ReadAddr = addr2;
            if (k == wr_at) begin
                a4.cm_WriteValid = 1'b1;
                a4.cm_WriteTag   = tag;
                a4.cm_WriteData  = d;
            end
            tick();
            a4.cm_WriteValid = 1'b0;
        end
        a4.cm_ReadValid = 1'b0;
        tick();
    endtask

    vec_t vecs[6];

    initial begin
        int t0;
        vecs[0] = '{1'b1, 28'h0000010, 32'hDEADBEEF, 32'h0000_0040, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 28'h0000020, 32'h1111_2222, 32'h0000_0080, 32'h1111_2222};
        vecs[2] = '{1'b1, 28'h0000005, 32'hA5A5_0005, 32'hFFFF_F014, 32'hA5A5_0005};
        vecs[3] = '{1'b1, 28'h12343FF, 32'h3FF3_3FF3, 32'h0000_0FFC, 32'h3FF3_3FF3};
        vecs[4] = '{1'b0, 28'h0000000, 32'h0000_0000, 32'h0000_1040, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 28'h0000020, 32'h7777_8888, 32'h0000_0080, 32'h7777_8888};

        Reset = 1'b1;
        a4.cm_ReadValid = 1'b0; a4.cm_ReadAddr = 32'd0;
        a4.cm_WriteValid = 1'b0; a4.cm_WriteTag = 28'd0; a4.cm_WriteData = 32'd0;
        a1.cm_ReadValid = 1'b0; a1.cm_ReadAddr = 32'd0;
        a1.cm_WriteValid = 1'b0; a1.cm_WriteTag = 28'd0; a1.cm_WriteData = 32'd0;
        repeat (2) tick();
        mon_en = 1'b1;
        chk("reset_busy4", 32'(busy4), 32'd0);
        chk("reset_ready4", 32'(a4.cm_ReadReady), 32'd0);
        chk("reset_busy1", 32'(busy1), 32'd0);
        chk("reset_ready1", 32'(a1.cm_ReadReady), 32'd0);
        Reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].wr_en) wr4(vecs[i].tag, vecs[i].wdata);
            rd4w(vecs[i].raddr, vecs[i].raddr, vecs[i].exp, -1, 28'd0, 32'd0);
        end

        // Address change after acceptance is ignored
        wr4(28'h0000020, 32'h2020_2020);
        rd4w(32'h40, 32'h80, 32'hDEADBEEF, -1, 28'd0, 32'd0);

        // Abort: valid dropped two cycles in
        a4.cm_ReadValid = 1'b1; a4.cm_ReadAddr = 32'h40;
        tick();
        chk("busy_wait", 32'(busy4), 32'd1);
        tick();
        a4.cm_ReadValid = 1'b0;
        tick();
        chk("busy_after_abort", 32'(busy4), 32'd0);
        repeat (10) tick();
        chk("busy_idle_abort", 32'(busy4), 32'd0);

        // Write forwarding in the load cycle, write during WAIT, write in acceptance cycle, non-matching write
        rd4w(32'h40, 32'h40, 32'h1234_5678, 3, 28'h0000010, 32'h1234_5678);
        rd4w(32'h40, 32'h40, 32'hCAFE_F00D, 1, 28'h0000010, 32'hCAFE_F00D);
        rd4w(32'h40, 32'h40, 32'h0102_0304, 0, 28'h0000010, 32'h0102_0304);
        rd4w(32'h80, 32'h80, 32'h2020_2020, 3, 28'h0000021, 32'h5555_AAAA);

        // Reset two cycles into a read, request held through it, write coincident with reset
        wr4(28'h0000010, 32'hDEADBEEF);
        a4.cm_ReadValid = 1'b1; a4.cm_ReadAddr = 32'h40;
        tick();
        tick();
        Reset = 1'b1;
        a4.cm_WriteValid = 1'b1; a4.cm_WriteTag = 28'h0000011; a4.cm_WriteData = 32'h5A5A_5A5A;
        tick();
        Reset = 1'b0;
        a4.cm_WriteValid = 1'b0;
        chk("busy_after_reset", 32'(busy4), 32'd0);
        q4.push_back('{cyc + 4, 32'hDEADBEEF});
        repeat (4) tick();
        a4.cm_ReadValid = 1'b0;
        tick();
        rd4w(32'h44, 32'h44, 32'h5A5A_5A5A, -1, 28'd0, 32'd0);

        // LATENCY=1 with valid held: ready, gap, ready, gap, ready
        a1.cm_WriteValid = 1'b1; a1.cm_WriteTag = 28'h0000010; a1.cm_WriteData = 32'h0BAD_CAFE;
        tick();
        a1.cm_WriteValid = 1'b0;
        a1.cm_ReadValid = 1'b1; a1.cm_ReadAddr = 32'h40;
        t0 = cyc;
        q1.push_back('{t0 + 1, 32'h0BAD_CAFE});
        q1.push_back('{t0 + 3, 32'h0BAD_CAFE});
        q1.push_back('{t0 + 5, 32'h0BAD_CAFE});
        repeat (5) tick();
        a1.cm_ReadValid = 1'b0;
        repeat (4) tick();

        chk("q4_drained", 32'(q4.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("final_busy4", 32'(busy4), 32'd0);
        chk("final_busy1", 32'(busy1), 32'd0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
